// File: rtl/carry_select_adder_pipe.sv
// Two-stage pipelined carry-select adder with rail-consistency fault detection.
// Stage 1 registers both speculative rails of every slice; stage 2 ripples the
// select chain, checks the rails against each other and counts faulting beats.
module carry_select_adder_pipe #(
   parameter  int WIDTH  = 32,
   parameter  int SLICE  = 4,
   parameter  int CNT_W  = 8,
   localparam int NSLICE = WIDTH / SLICE,
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              cin,
   input  logic [NSLICE-1:0] inj_mask,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  sum,
   output logic              cout,
   output logic              fault,
   output logic [IDXW-1:0]   fault_slice,
   output logic [CNT_W-1:0]  fault_count,
   input  logic              clr_count
);

   logic [NSLICE-1:0][SLICE-1:0] w_s0, w_s1;
   logic [NSLICE-1:0]            w_c0, w_c1;

   logic [NSLICE-1:0][SLICE-1:0] r_s0, r_s1;
   logic [NSLICE-1:0]            r_c0, r_c1;
   logic                         r_cin1;
   logic                         r_v1;

   logic [WIDTH-1:0]  r_sum;
   logic              r_cout;
   logic              r_fault;
   logic [IDXW-1:0]   r_fault_slice;
   logic              r_out_valid;
   logic [CNT_W-1:0]  r_fault_count;

   logic [WIDTH-1:0]  w_sum;
   logic              w_cout;
   logic [NSLICE-1:0] w_bad;
   logic [IDXW-1:0]   w_idx;
   logic              w_en1, w_en2, w_load1, w_load2;

   // Handshake: stage 2 frees when empty or draining, stage 1 when stage 2 frees.
   always_comb begin
      w_en2   = !r_out_valid || out_ready;
      w_en1   = !r_v1 || w_en2;
      w_load1 = in_valid && w_en1;
      w_load2 = r_v1 && w_en2;
   end

   assign in_ready = w_en1;

   // Both speculative rails per slice; injection flips bit 0 of the carry-in-1 rail.
   always_comb begin
      w_s0 = '0;
      w_s1 = '0;
      w_c0 = '0;
      w_c1 = '0;
      for (int i = 0; i < NSLICE; i++) begin
         logic [SLICE:0] t0, t1;
         t0 = {1'b0, a[i*SLICE +: SLICE]} + {1'b0, b[i*SLICE +: SLICE]};
         t1 = {1'b0, a[i*SLICE +: SLICE]} + {1'b0, b[i*SLICE +: SLICE]} + (SLICE+1)'(1);
         w_s0[i] = t0[SLICE-1:0];
         w_c0[i] = t0[SLICE];
         w_s1[i] = t1[SLICE-1:0] ^ {{(SLICE-1){1'b0}}, inj_mask[i]};
         w_c1[i] = t1[SLICE];
      end
   end

   // Select chain plus rail check on every slice, selected or not.
   always_comb begin
      logic k;
      k     = r_cin1;
      w_sum = '0;
      w_bad = '0;
      w_idx = '0;
      for (int i = 0; i < NSLICE; i++) begin
         w_sum[i*SLICE +: SLICE] = k ? r_s1[i] : r_s0[i];
         k        = k ? r_c1[i] : r_c0[i];
         w_bad[i] = (r_s1[i] != (r_s0[i] + SLICE'(1))) ||
                    (r_c1[i] != (r_c0[i] | (&r_s0[i])));
      end
      w_cout = k;
      for (int i = NSLICE - 1; i >= 0; i--) begin
         if (w_bad[i]) w_idx = IDXW'(i);
      end
   end

   // Stage 1: capture rails on input transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_s0   <= '0;
         r_s1   <= '0;
         r_c0   <= '0;
         r_c1   <= '0;
         r_cin1 <= 1'b0;
      end else begin
         if (w_en1) r_v1 <= in_valid;
         if (w_load1) begin
            r_s0   <= w_s0;
            r_s1   <= w_s1;
            r_c0   <= w_c0;
            r_c1   <= w_c1;
            r_cin1 <= cin;
         end
      end
   end

   // Stage 2: result register, held stable while stalled downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_sum         <= '0;
         r_cout        <= 1'b0;
         r_fault       <= 1'b0;
         r_fault_slice <= '0;
      end else begin
         if (w_en2) r_out_valid <= r_v1;
         if (w_load2) begin
            r_sum         <= w_sum;
            r_cout        <= w_cout;
            r_fault       <= |w_bad;
            r_fault_slice <= w_idx;
         end
      end
   end

   // Saturating count of faulting stage-2 loads; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_count <= '0;
      end else if (clr_count) begin
         r_fault_count <= '0;
      end else if (w_load2 && (|w_bad) && !(&r_fault_count)) begin
         r_fault_count <= r_fault_count + CNT_W'(1);
      end
   end

   assign out_valid   = r_out_valid;
   assign sum         = r_sum;
   assign cout        = r_cout;
   assign fault       = r_fault;
   assign fault_slice = r_fault_slice;
   assign fault_count = r_fault_count;

endmodule

// File: tb/tb_carry_select_adder_pipe.sv
// Directed and streamed checks of the pipelined carry-select adder.
module tb_carry_select_adder_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        cin;
   logic [7:0]  inj_mask;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        fault;
   logic [2:0]  fault_slice;
   logic [7:0]  fault_count;
   logic        clr_count;

   int errors = 0;
   int checks = 0;

   carry_select_adder_pipe #(.WIDTH(32), .SLICE(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .inj_mask(inj_mask),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
      .fault(fault), .fault_slice(fault_slice), .fault_count(fault_count),
      .clr_count(clr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
      inj_mask = '0; out_ready = 1'b1; clr_count = 1'b0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (sum !== 32'h0 || cout !== 1'b0) begin errors++; $display("FAIL reset_sum: got %h/%b want 0/0", sum, cout); end
      checks++; if (fault !== 1'b0 || fault_slice !== 3'd0) begin errors++; $display("FAIL reset_fault: got %b/%0d want 0/0", fault, fault_slice); end
      checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fault_count); end
      rst_n = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      tick();
   endtask

   task automatic test_single_add();
      logic [31:0] va [7] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0000_000F,
                              32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h7FFF_FFFF};
      logic [31:0] vb [7] = '{32'h0000_0000, 32'h8765_4321, 32'h8000_0000, 32'h0000_0001,
                              32'hFFFF_FFFF, 32'h00F0_F0F0, 32'h0000_0000};
      logic        vc [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] es [7] = '{32'h0000_0000, 32'h9999_9999, 32'h0000_0000, 32'h0000_0010,
                              32'hFFFF_FFFF, 32'h1000_0000, 32'h8000_0000};
      logic        ec [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add%0d_early: out_valid got %b want 0", i, out_valid); end
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add%0d_valid: got %b want 1", i, out_valid); end
         checks++; if (sum !== es[i] || cout !== ec[i]) begin errors++; $display("FAIL add%0d_sum: got %h/%b want %h/%b", i, sum, cout, es[i], ec[i]); end
         checks++; if (fault !== 1'b0) begin errors++; $display("FAIL add%0d_fault: got %b want 0", i, fault); end
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add%0d_drain: got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_stream();
      localparam int N = 300;
      logic [32:0] q [$];
      logic [32:0] exp_v;
      int sent = 0, got = 0, cyc = 0;
      out_ready = 1'b1;
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      while (got < N && cyc < N + 20) begin
         @(negedge clk);
         cyc++;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b want 1 at cycle %0d", in_ready, cyc); end
         if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL stream_extra: got unexpected beat %h want none", sum);
            end else begin
               exp_v = q.pop_front();
               if ({cout, sum} !== exp_v) begin errors++; $display("FAIL stream_beat%0d: got %h want %h", got, {cout, sum}, exp_v); end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back({1'b0, a} + {1'b0, b} + 33'(cin));
            sent++;
         end
         tick();
         if (sent < N) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
      end
      checks++; if (got !== N) begin errors++; $display("FAIL stream_count: got %0d want %0d", got, N); end
      checks++; if (cyc !== N + 2) begin errors++; $display("FAIL stream_cycles: got %0d want %0d", cyc, N + 2); end
   endtask

   task automatic test_backpressure();
      localparam int N = 200;
      logic [32:0] q [$];
      logic [32:0] exp_v, held_v;
      logic        held, ifire, ofire, exp_rdy;
      int sent = 0, got = 0, cyc = 0, n = 0;
      held = 1'b0; held_v = '0;
      out_ready = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      while (got < N && cyc < 20 * N) begin
         @(negedge clk);
         cyc++;
         exp_rdy = !(n == 2 && !out_ready);
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready: got %b want %b at cycle %0d", in_ready, exp_rdy, cyc); end
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || {cout, sum} !== held_v) begin
               errors++; $display("FAIL bp_hold: got %b/%h want 1/%h", out_valid, {cout, sum}, held_v);
            end
         end
         ofire = out_valid && out_ready;
         ifire = in_valid && in_ready;
         if (ofire) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL bp_extra: got unexpected beat %h want none", sum);
            end else begin
               exp_v = q.pop_front();
               if ({cout, sum} !== exp_v) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", got, {cout, sum}, exp_v); end
            end
            got++;
         end
         if (ifire) begin
            q.push_back({1'b0, a} + {1'b0, b} + 33'(cin));
            sent++;
         end
         held   = out_valid && !out_ready;
         held_v = {cout, sum};
         n      = n + int'(ifire) - int'(ofire);
         tick();
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid || ifire) begin
            in_valid = (sent < N) ? ($urandom_range(0, 3) != 0) : 1'b0;
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
         end
      end
      checks++; if (got !== N) begin errors++; $display("FAIL bp_count: got %0d want %0d", got, N); end
      checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d want 0", q.size()); end
      out_ready = 1'b1; in_valid = 1'b0;
      tick(); tick();
   endtask

   task automatic test_inject();
      a = '0; b = '0; cin = 1'b0; inj_mask = 8'h04; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; inj_mask = '0;
      tick();
      checks++; if (out_valid !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL inj1_fault: got %b/%b want 1/1", out_valid, fault); end
      checks++; if (fault_slice !== 3'd2) begin errors++; $display("FAIL inj1_slice: got %0d want 2", fault_slice); end
      checks++; if (sum !== 32'h0 || cout !== 1'b0) begin errors++; $display("FAIL inj1_sum: got %h/%b want 0/0", sum, cout); end
      checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL inj1_count: got %0d want 1", fault_count); end
      cin = 1'b1; inj_mask = 8'hA0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; inj_mask = '0; cin = 1'b0;
      tick();
      checks++; if (fault !== 1'b1 || fault_slice !== 3'd5) begin errors++; $display("FAIL inj2_slice: got %b/%0d want 1/5", fault, fault_slice); end
      checks++; if (sum !== 32'h1) begin errors++; $display("FAIL inj2_sum: got %h want 00000001", sum); end
      checks++; if (fault_count !== 8'd2) begin errors++; $display("FAIL inj2_count: got %0d want 2", fault_count); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (fault !== 1'b0 || fault_slice !== 3'd0) begin errors++; $display("FAIL inj_clean: got %b/%0d want 0/0", fault, fault_slice); end
      checks++; if (fault_count !== 8'd2) begin errors++; $display("FAIL inj_clean_count: got %0d want 2", fault_count); end
      tick();
   endtask

   task automatic test_counter();
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL cnt_clear: got %0d want 0", fault_count); end
      a = 32'h0000_1234; b = 32'h0000_0001; cin = 1'b0; inj_mask = 8'h01; in_valid = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 11) begin
            checks++; if (fault_count !== 8'd10) begin errors++; $display("FAIL cnt_10: got %0d want 10", fault_count); end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL cnt_sat: got %0d want 255", fault_count); end
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      checks++; if (out_valid !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL cnt_clr_load: got %b/%b want 1/1", out_valid, fault); end
      checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL cnt_clr_prio: got %0d want 0", fault_count); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL cnt_after_clr: got %0d want 1", fault_count); end
      inj_mask = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; inj_mask = 8'h01; a = 32'h5; b = 32'h6; in_valid = 1'b1;
      tick(); tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: in_ready got %b want 0", in_ready); end
      checks++; if (fault_count !== 8'd2) begin errors++; $display("FAIL mid_pre_count: got %0d want 2", fault_count); end
      rst_n = 1'b0;
      #2;
      checks++; if (out_valid !== 1'b0 || fault_count !== 8'd0) begin errors++; $display("FAIL mid_async: got %b/%0d want 0/0", out_valid, fault_count); end
      tick();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inj_mask = '0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got %b want 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_stream();
      test_backpressure();
      test_inject();
      test_counter();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
